// File: rtl/pipe_stage_reg_n_if.sv
// Inter-stage pipeline bus: upstream payload, hazard-unit controls and the
// registered stage outputs seen by the downstream stage.
interface pipe_stage_reg_n_if #(
  parameter int unsigned WIDTH = 71,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
);
  logic [LANES-1:0]       in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   stall;
  logic                   flush;
  logic [LANES-1:0]       kill_mask;
  logic                   clr_cnt;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   occupied;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       bubble_cnt;

  modport master (
    output in_valid, in_data, stall, flush, kill_mask, clr_cnt,
    input  out_valid, out_data, occupied, stall_cnt, bubble_cnt
  );

  modport slave (
    input  in_valid, in_data, stall, flush, kill_mask, clr_cnt,
    output out_valid, out_data, occupied, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_n.sv
// N-lane pipeline register with stall/flush/squash and saturating
// stall and bubble performance counters.
module pipe_stage_reg_n #(
  parameter int unsigned WIDTH = 71,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               areset,
  pipe_stage_reg_n_if.slave  bus
);

  logic [LANES-1:0]       valid_q, valid_d;
  logic [LANES*WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W:0]         bubble_inc;

  // One extra carry bit detects overflow so the counter clamps instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + b;
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    bubble_inc   = '0;
    if (bus.flush) begin
      valid_d = '0;
    end else if (bus.stall) begin
      valid_d     = valid_q & ~bus.kill_mask;
      stall_cnt_d = sat_add(stall_cnt_q, (CNT_W+1)'(1));
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        valid_d[i] = bus.in_valid[i] & ~bus.kill_mask[i];
        // Lanes without valid input keep their old payload to avoid toggling.
        if (bus.in_valid[i]) begin
          data_d[i*WIDTH +: WIDTH] = bus.in_data[i*WIDTH +: WIDTH];
        end
        if (!valid_d[i]) begin
          bubble_inc = bubble_inc + (CNT_W+1)'(1);
        end
      end
      bubble_cnt_d = sat_add(bubble_cnt_q, bubble_inc);
    end
    if (bus.clr_cnt) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      valid_q      <= '0;
      data_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.occupied   = |valid_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg_n.sv
// Directed-vector bench for pipe_stage_reg_n (2 lanes, 3-bit counters) with a
// queue-based scoreboard checked by an independent monitor.
module tb_pipe_stage_reg_n;
  localparam int unsigned W  = 71;
  localparam int unsigned L  = 2;
  localparam int unsigned CW = 3;

  logic clk;
  logic areset;

  pipe_stage_reg_n_if #(.WIDTH(W), .LANES(L), .CNT_W(CW)) bus ();

  pipe_stage_reg_n #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  bc;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic cmp(input string nm, input logic [L*W-1:0] act, input logic [L*W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: the register presents a new output every cycle, so every
  // posedge that the driver scored is checked at the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.name, ".out_valid"},  (L*W)'(bus.out_valid),  (L*W)'(e.v));
        cmp({e.name, ".out_data"},   bus.out_data,           e.d);
        cmp({e.name, ".occupied"},   (L*W)'(bus.occupied),   (L*W)'(|e.v));
        cmp({e.name, ".stall_cnt"},  (L*W)'(bus.stall_cnt),  (L*W)'(e.sc));
        cmp({e.name, ".bubble_cnt"}, (L*W)'(bus.bubble_cnt), (L*W)'(e.bc));
      end
    end
  end

  task automatic step(input logic rst, input logic [L-1:0] iv,
                      input logic [W-1:0] l0, input logic [W-1:0] l1,
                      input logic st, input logic fl, input logic [L-1:0] km,
                      input logic clr, input logic [L-1:0] ev,
                      input logic [W-1:0] e0, input logic [W-1:0] e1,
                      input logic [CW-1:0] esc, input logic [CW-1:0] ebc,
                      input string nm);
    exp_t e;
    areset        = rst;
    bus.in_valid  = iv;
    bus.in_data   = {l1, l0};
    bus.stall     = st;
    bus.flush     = fl;
    bus.kill_mask = km;
    bus.clr_cnt   = clr;
    e.v = ev; e.d = {e1, e0}; e.sc = esc; e.bc = ebc; e.name = nm;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    areset = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.kill_mask = '0; bus.clr_cnt = 1'b0;
    @(negedge clk);

    //    rst iv     l0  l1  st fl km     clr  ev     e0  e1  sc bc
    step(1, 2'b11, 7,  8,  0, 0, 2'b00, 0, 2'b00, 0,  0,  0, 0, "reset");
    step(0, 2'b11, 1,  2,  0, 0, 2'b00, 0, 2'b11, 1,  2,  0, 0, "load");
    step(0, 2'b11, 3,  4,  1, 0, 2'b00, 0, 2'b11, 1,  2,  1, 0, "stall1");
    step(0, 2'b11, 3,  4,  1, 0, 2'b10, 0, 2'b01, 1,  2,  2, 0, "stall2_kill");
    step(0, 2'b11, 3,  4,  1, 0, 2'b00, 0, 2'b01, 1,  2,  3, 0, "stall3");
    step(0, 2'b11, 3,  4,  1, 1, 2'b00, 0, 2'b00, 1,  2,  3, 0, "stall_flush");
    step(0, 2'b01, 5,  9,  0, 0, 2'b00, 0, 2'b01, 5,  2,  3, 1, "partial");
    step(0, 2'b11, 6,  10, 0, 0, 2'b01, 0, 2'b10, 6,  10, 3, 2, "kill_lane0");
    step(0, 2'b11, 11, 12, 0, 1, 2'b10, 0, 2'b00, 6,  10, 3, 2, "flush");
    for (int i = 0; i < 10; i++) begin
      logic [CW-1:0] sc;
      sc = (i < 4) ? CW'(4 + i) : CW'(7);
      step(0, 2'b11, 13, 14, 1, 0, 2'b00, 0, 2'b00, 6, 10, sc, 2, $sformatf("sat_stall%0d", i));
    end
    step(0, 2'b00, 0,  0,  1, 0, 2'b00, 1, 2'b00, 6,  10, 0, 0, "clr_stall");
    step(0, 2'b00, 15, 16, 0, 0, 2'b00, 0, 2'b00, 6,  10, 0, 2, "bubble2");
    step(0, 2'b00, 15, 16, 0, 0, 2'b00, 0, 2'b00, 6,  10, 0, 4, "bubble4");
    step(0, 2'b00, 15, 16, 0, 0, 2'b00, 0, 2'b00, 6,  10, 0, 6, "bubble6");
    step(0, 2'b00, 15, 16, 0, 0, 2'b00, 0, 2'b00, 6,  10, 0, 7, "bubble_sat");
    step(0, 2'b00, 15, 16, 0, 0, 2'b00, 0, 2'b00, 6,  10, 0, 7, "bubble_hold");
    step(0, 2'b11, 17, 18, 1, 0, 2'b00, 0, 2'b00, 6,  10, 1, 7, "pre_rst_stall");
    step(1, 2'b11, 17, 18, 1, 0, 2'b00, 0, 2'b00, 0,  0,  0, 0, "reset_mid_stall");
    step(0, 2'b10, 19, 20, 0, 0, 2'b00, 1, 2'b10, 0,  20, 0, 0, "clr_load");

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_reg_n.md
Name: pipe_stage_reg_n

Overview:
- Parametrised inter-stage pipeline register for the superscalar core; generalises the fixed-width MEM/WB register to N lanes of WIDTH bits.
- Per-lane valid tracking, stall (hold), flush (bubble), per-lane squash, and saturating stall/bubble performance counters.
- Instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives stall/flush/kill.

Parameters:
- WIDTH, 71, payload bits per lane
- LANES, 2, number of issue lanes (>=1)
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  rising-edge clock
- areset  input  1  synchronous active-high reset
- in_valid  input  LANES  per-lane valid from upstream stage
- in_data  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- stall  input  1  hold register contents this cycle
- flush  input  1  invalidate all lanes this cycle
- kill_mask  input  LANES  per-lane squash (bit i kills lane i)
- clr_cnt  input  1  synchronous clear of both counters
- out_valid  output  LANES  registered per-lane valid
- out_data  output  LANES*WIDTH  registered payload, same packing as in_data
- occupied  output  1  OR-reduction of out_valid, combinational from registers
- stall_cnt  output  CNT_W  stalled-cycle count
- bubble_cnt  output  CNT_W  invalid-lane-slot count

Behaviour:
- All state updates on the rising edge of clk; no asynchronous paths.
- Priority per cycle: areset > flush > stall > load.
- areset=1: out_valid=0, out_data=0, stall_cnt=0, bubble_cnt=0; occupied=0. Takes effect mid-stall or mid-flush without exception.
- flush=1, areset=0: out_valid <= 0. out_data holds its previous value. Counters are not incremented (stall is ignored when flush=1).
- stall=1, flush=0:
  - out_data holds.
  - out_valid <= out_valid & ~kill_mask (in-place squash of held instructions).
  - stall_cnt increments by 1.
- Load (stall=0, flush=0):
  - For each lane i, out_valid[i] <= in_valid[i] & ~kill_mask[i].
  - out_data lane i <= in_data lane i only when in_valid[i]=1; otherwise that lane's data holds (power gating).
  - A killed valid lane still loads data, with valid=0.
  - bubble_cnt increments by the number of lanes whose new out_valid is 0 (0..LANES; width-extended to CNT_W before the add).
- Latency: one cycle from in_* to out_*. No combinational path from inputs to outputs.
- Counters:
  - Saturate at 2^CNT_W-1: an add that would exceed this clamps to all-ones, with no wrap.
  - clr_cnt=1 (areset=0) forces both counters to 0 that cycle. Clear wins over a same-cycle increment; the register/valid update proceeds normally.
  - The counters never affect datapath state.
- kill_mask is ignored during areset and flush. The result is identical (all lanes invalid).
- Simultaneous stall and flush: flush wins. All lanes are invalidated and stall_cnt does not increment.
- LANES=1 must elaborate and behave identically with scalar masks.

Test Plan:
- Reset: drive in_valid=2'b11, in_data nonzero, assert areset 1 cycle -> next cycle out_valid=00, out_data=0, both counters 0, occupied=0.
- Load/latency: in_valid=11, lane0=71'h1, lane1=71'h2 -> one cycle later out_valid=11, out_data={71'h2,71'h1}; bubble_cnt stays 0.
- Stall with squash:
  - Registers hold 11/{2,1}. Assert stall 3 cycles with new inputs and kill_mask=10 in cycle 2.
  - Result: data stays {2,1}; out_valid=11,01,01; stall_cnt=3.
- Flush vs stall: assert stall=1, flush=1 together -> out_valid=00, out_data unchanged, stall_cnt unchanged.
- Partial valid/power gating:
  - Load in_valid=01, lane0=5, lane1=9, over prior lane1=2.
  - Result: out_valid=01, lane0=5, lane1 still 2; bubble_cnt +1.
  - Then in_valid=11, kill_mask=01 -> out_valid=10, bubble_cnt +1.
- Saturation/clear:
  - With CNT_W=3, hold stall 10 cycles -> stall_cnt reaches 7 and stays 7.
  - Load in_valid=00 with bubble_cnt=6 -> bubble_cnt=7 (clamped, not 8 or 0).
  - Assert clr_cnt together with stall -> both counters 0 next cycle.
